// File: rtl/barker_pkg.sv
// Shared Barker-11 definitions used by the serializer and the downstream correlator.
package barker_pkg;

  localparam int BARKER_LEN = 11;
  localparam logic [BARKER_LEN-1:0] BARKER11 = 11'b11100010010;

  typedef logic [BARKER_LEN-1:0] barker_word_t;

endpackage

// File: rtl/barker_bit_serializer_if.sv
// Word-wide slave stream in, 1-bit master stream out, bundled for the serializer.
interface barker_bit_serializer_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;

  // slave: the serializer itself; master: whoever feeds words and drains bits
  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/barker_bit_serializer.sv
// Serializes FRAME_LEN-bit words MSB-first with tlast framing; shift stage plus
// one holding stage lets frames run back-to-back with a registered s_tready.
module barker_bit_serializer
  import barker_pkg::*;
#(
  parameter int FRAME_LEN = BARKER_LEN,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  barker_bit_serializer_if.slave  bus,
  output logic                    o_busy,
  output logic [CNT_W-1:0]        o_frame_cnt
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);

  if (FRAME_LEN < 2 || FRAME_LEN > DATA_W) begin : g_bad_cfg
    $error("barker_bit_serializer: FRAME_LEN must lie in 2..DATA_W");
  end

  logic [FRAME_LEN-1:0] sh_q, sh_d, hold_q, hold_d;
  logic                 sh_vld_q, sh_vld_d, hold_vld_q, hold_vld_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 s_tready_q, s_tready_d;
  logic                 s_xfer, m_xfer, m_last;

  always_comb begin
    sh_d        = sh_q;
    sh_vld_d    = sh_vld_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    s_xfer      = bus.s_tvalid & s_tready_q;
    m_xfer      = sh_vld_q & bus.m_tready;
    m_last      = sh_vld_q && (bit_cnt_q == LAST_BIT);

    if (m_xfer && !m_last) begin
      sh_d      = {sh_q[FRAME_LEN-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (m_xfer && m_last) begin
      bit_cnt_d   = '0;
      frame_cnt_d = frame_cnt_q + 1'b1;
      // Refill the shift stage on the last bit so the next frame starts with no gap
      if (hold_vld_q) begin
        sh_d       = hold_q;
        hold_vld_d = 1'b0;
      end else if (s_xfer) begin
        sh_d = bus.s_tdata[FRAME_LEN-1:0];
      end else begin
        sh_vld_d = 1'b0;
      end
    end else if (s_xfer) begin
      if (!sh_vld_q) begin
        sh_d     = bus.s_tdata[FRAME_LEN-1:0];
        sh_vld_d = 1'b1;
      end else begin
        hold_d     = bus.s_tdata[FRAME_LEN-1:0];
        hold_vld_d = 1'b1;
      end
    end

    s_tready_d = ~hold_vld_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sh_q        <= '0;
      sh_vld_q    <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      s_tready_q  <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      sh_vld_q    <= sh_vld_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      s_tready_q  <= s_tready_d;
    end
  end

  assign bus.s_tready = s_tready_q;
  assign bus.m_tdata  = sh_q[FRAME_LEN-1];
  assign bus.m_tvalid = sh_vld_q;
  assign bus.m_tlast  = sh_vld_q && (bit_cnt_q == LAST_BIT);
  assign o_busy       = sh_vld_q | hold_vld_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_barker_bit_serializer.sv
// Bench for barker_bit_serializer: scenario tasks against a bit-queue reference model.
module tb_barker_bit_serializer;
  import barker_pkg::*;

  localparam int FL = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  barker_bit_serializer_if #(.DATA_W(DW)) bus ();
  barker_bit_serializer_if #(.DATA_W(DW)) bus2 ();
  logic        busy, busy2;
  logic [15:0] fcnt;
  logic [3:0]  fcnt2;

  barker_bit_serializer #(.FRAME_LEN(FL), .DATA_W(DW), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_busy(busy), .o_frame_cnt(fcnt));

  barker_bit_serializer #(.FRAME_LEN(FL), .DATA_W(DW), .CNT_W(4)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus2), .o_busy(busy2), .o_frame_cnt(fcnt2));

  typedef struct { logic d; logic l; } beat_t;
  beat_t exp_q[$];
  int    mfc;
  int    n_chk = 0;
  int    n_fail = 0;

  logic        o_mv, o_md, o_ml, o_sr, o_busy, s_hs, m_hs;
  logic [15:0] o_cnt;

  // Reference: each accepted word contributes its FL low bits, MSB first, tlast on the final one.
  function automatic void model_push(input logic [15:0] w);
    for (int i = 0; i < FL; i++) begin
      beat_t b;
      b.d = w[FL-1-i];
      b.l = (i == FL-1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic beat_t pop_exp();
    beat_t e;
    e.d = 1'bx;
    e.l = 1'bx;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.l) mfc++;
    end
    return e;
  endfunction

  // One clock: drive after the edge, sample at the falling edge (pre-next-edge state).
  task automatic cyc(input logic rn, input logic sv, input logic [15:0] sd, input logic mr);
    @(posedge clk); #1;
    rst_n = rn; bus.s_tvalid = sv; bus.s_tdata = sd; bus.m_tready = mr;
    @(negedge clk);
    o_mv = bus.m_tvalid; o_md = bus.m_tdata; o_ml = bus.m_tlast; o_sr = bus.s_tready;
    o_busy = busy; o_cnt = fcnt;
    s_hs = sv && o_sr;
    m_hs = o_mv && mr;
  endtask

  task automatic test_reset();
    repeat (2) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    n_chk += 6;
    if (o_mv !== 1'b0) begin n_fail++; $display("FAIL reset_mtvalid got %b want 0", o_mv); end
    if (o_md !== 1'b0) begin n_fail++; $display("FAIL reset_mtdata got %b want 0", o_md); end
    if (o_ml !== 1'b0) begin n_fail++; $display("FAIL reset_mtlast got %b want 0", o_ml); end
    if (o_sr !== 1'b0) begin n_fail++; $display("FAIL reset_stready got %b want 0", o_sr); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    if (o_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", o_cnt); end
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    n_chk++;
    if (o_sr !== 1'b1) begin n_fail++; $display("FAIL reset_release_stready got %b want 1", o_sr); end
    mfc = 0;
  endtask

  // Single word 0x0712, or 0xF712 when checking that bits above FRAME_LEN are ignored.
  task automatic test_single(input logic [15:0] w, input string nm);
    logic pend = 1'b1;
    int acc = -1, first_v = -1;
    logic [FL-1:0] got = '0;
    beat_t e;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, pend, w, 1'b1);
      if (o_mv && first_v < 0) first_v = c;
      if (s_hs) begin pend = 1'b0; acc = c; model_push(16'h0712); end
      if (m_hs) begin
        e = pop_exp();
        got = {got[FL-2:0], o_md};
        n_chk++;
        if ({o_md, o_ml} !== {e.d, e.l}) begin
          n_fail++; $display("FAIL %s_beat got d=%b l=%b want d=%b l=%b", nm, o_md, o_ml, e.d, e.l);
        end
      end
    end
    n_chk += 5;
    if (first_v !== acc + 1) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", nm, first_v, acc + 1); end
    if (got !== 11'b11100010010) begin n_fail++; $display("FAIL %s_bits got %b want 11100010010", nm, got); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_drain got %0d left want 0", nm, exp_q.size()); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy got %b want 0", nm, o_busy); end
    if (o_cnt !== 16'(mfc)) begin n_fail++; $display("FAIL %s_cnt got %0d want %0d", nm, o_cnt, mfc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[3];
    int idx = 0, nb = 0, run = 0, max_run = 0, t_last1 = -1;
    int a[3] = '{-1, -1, -1};
    beat_t e;
    for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
    for (int c = 0; c < 60; c++) begin
      cyc(1'b1, idx < 3, (idx < 3) ? w[idx] : 16'h0, 1'b1);
      if (a[1] >= 0 && c == a[1] + 1) begin
        n_chk++;
        if (o_sr !== 1'b0) begin n_fail++; $display("FAIL b2b_full_stready got %b want 0", o_sr); end
      end
      if (t_last1 >= 0 && c == t_last1 + 1) begin
        n_chk++;
        if (o_sr !== 1'b1) begin n_fail++; $display("FAIL b2b_stready_rise got %b want 1", o_sr); end
      end
      if (o_mv) begin run++; if (run > max_run) max_run = run; end else run = 0;
      if (s_hs) begin model_push(w[idx]); a[idx] = c; idx++; end
      if (m_hs) begin
        e = pop_exp();
        nb++;
        if (nb == FL) t_last1 = c;
        n_chk++;
        if ({o_md, o_ml} !== {e.d, e.l}) begin
          n_fail++; $display("FAIL b2b_beat%0d got d=%b l=%b want d=%b l=%b", nb, o_md, o_ml, e.d, e.l);
        end
      end
    end
    n_chk += 3;
    if (max_run != 3 * FL) begin n_fail++; $display("FAIL b2b_contiguous got %0d want %0d", max_run, 3 * FL); end
    if (a[2] != t_last1 + 1) begin n_fail++; $display("FAIL b2b_third_accept got %0d want %0d", a[2], t_last1 + 1); end
    if (exp_q.size() != 0 || nb != 3 * FL) begin n_fail++; $display("FAIL b2b_count got %0d beats want %0d", nb, 3 * FL); end
  endtask

  task automatic test_backpressure();
    logic pend = 1'b1, mr, pmv = 1'b0, pmr = 1'b1, pmd = 1'b0, pml = 1'b0;
    logic [FL-1:0] got = '0;
    beat_t e;
    for (int c = 0; c < 40; c++) begin
      mr = (c % 2 == 0);
      cyc(1'b1, pend, 16'h0712, mr);
      if (pmv && !pmr) begin
        n_chk++;
        if ({o_mv, o_md, o_ml} !== {1'b1, pmd, pml}) begin
          n_fail++; $display("FAIL bp_stall got v=%b d=%b l=%b want v=1 d=%b l=%b", o_mv, o_md, o_ml, pmd, pml);
        end
      end
      if (s_hs) begin pend = 1'b0; model_push(16'h0712); end
      if (m_hs) begin
        e = pop_exp();
        got = {got[FL-2:0], o_md};
        n_chk++;
        if ({o_md, o_ml} !== {e.d, e.l}) begin
          n_fail++; $display("FAIL bp_beat got d=%b l=%b want d=%b l=%b", o_md, o_ml, e.d, e.l);
        end
      end
      pmv = o_mv; pmr = mr; pmd = o_md; pml = o_ml;
    end
    n_chk += 2;
    if (got !== BARKER11) begin n_fail++; $display("FAIL bp_bits got %b want %b", got, BARKER11); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[2];
    int idx = 0, nb = 0;
    logic pend = 1'b1;
    logic [FL-1:0] got = '0;
    beat_t e;
    w[0] = 16'h0712;
    w[1] = 16'($urandom);
    for (int c = 0; c < 20 && nb < 5; c++) begin
      cyc(1'b1, idx < 2, (idx < 2) ? w[idx] : 16'h0, 1'b1);
      if (s_hs) begin model_push(w[idx]); idx++; end
      if (m_hs) begin
        e = pop_exp(); nb++;
        n_chk++;
        if ({o_md, o_ml} !== {e.d, e.l}) begin
          n_fail++; $display("FAIL rstmid_beat got d=%b l=%b want d=%b l=%b", o_md, o_ml, e.d, e.l);
        end
      end
    end
    n_chk++;
    if (idx != 2) begin n_fail++; $display("FAIL rstmid_held got %0d accepted want 2", idx); end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b1);
    exp_q.delete();
    mfc = 0;
    n_chk += 3;
    if (o_mv !== 1'b0) begin n_fail++; $display("FAIL rstmid_mtvalid got %b want 0", o_mv); end
    if (o_sr !== 1'b0) begin n_fail++; $display("FAIL rstmid_stready got %b want 0", o_sr); end
    if (o_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt got %0d want 0", o_cnt); end
    cyc(1'b1, 1'b0, 16'h0, 1'b1);
    n_chk++;
    if (o_sr !== 1'b1) begin n_fail++; $display("FAIL rstmid_stready_rise got %b want 1", o_sr); end
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, pend, 16'h0555, 1'b1);
      if (s_hs) begin pend = 1'b0; model_push(16'h0555); end
      if (m_hs) begin
        e = pop_exp();
        got = {got[FL-2:0], o_md};
        n_chk++;
        if ({o_md, o_ml} !== {e.d, e.l}) begin
          n_fail++; $display("FAIL rstmid_next_beat got d=%b l=%b want d=%b l=%b", o_md, o_ml, e.d, e.l);
        end
      end
    end
    n_chk += 2;
    if (got !== 11'b10101010101) begin n_fail++; $display("FAIL rstmid_next_bits got %b want 10101010101", got); end
    if (o_cnt !== 16'd1) begin n_fail++; $display("FAIL rstmid_next_cnt got %0d want 1", o_cnt); end
  endtask

  // Random traffic on both sides; occupancy and flags derived from how many words still owe bits.
  task automatic test_random();
    logic sv, mr, pmv = 1'b0, pmr = 1'b1, pmd = 1'b0, pml = 1'b0;
    int words;
    beat_t e;
    for (int c = 0; c < 460; c++) begin
      sv = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      mr = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc(1'b1, sv, 16'($urandom), mr);
      words = (exp_q.size() + FL - 1) / FL;
      n_chk++;
      if ({o_sr, o_busy, o_mv} !== {words < 2, words > 0, words > 0}) begin
        n_fail++; $display("FAIL rand_occ c=%0d got sr=%b busy=%b v=%b want words=%0d", c, o_sr, o_busy, o_mv, words);
      end
      if (pmv && !pmr) begin
        n_chk++;
        if ({o_mv, o_md, o_ml} !== {1'b1, pmd, pml}) begin
          n_fail++; $display("FAIL rand_stall got v=%b d=%b l=%b want v=1 d=%b l=%b", o_mv, o_md, o_ml, pmd, pml);
        end
      end
      if (s_hs) model_push(bus.s_tdata);
      if (m_hs) begin
        e = pop_exp();
        n_chk++;
        if ({o_md, o_ml} !== {e.d, e.l}) begin
          n_fail++; $display("FAIL rand_beat c=%0d got d=%b l=%b want d=%b l=%b", c, o_md, o_ml, e.d, e.l);
        end
      end
      pmv = o_mv; pmr = mr; pmd = o_md; pml = o_ml;
    end
    n_chk += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d left want 0", exp_q.size()); end
    if (o_cnt !== 16'(mfc)) begin n_fail++; $display("FAIL rand_cnt got %0d want %0d", o_cnt, mfc); end
  endtask

  task automatic test_wrap();
    int acc = 0, frames = 0;
    logic done = 1'b0;
    for (int c = 0; c < 17 * FL + 30; c++) begin
      @(posedge clk); #1;
      bus2.s_tvalid = (acc < 17);
      bus2.s_tdata  = 16'($urandom);
      bus2.m_tready = 1'b1;
      @(negedge clk);
      if (done) begin
        n_chk++;
        if (fcnt2 !== 4'(frames)) begin n_fail++; $display("FAIL wrap_cnt got %0d want %0d", fcnt2, frames % 16); end
        if (frames >= 15 && frames <= 17) begin
          n_chk++;
          if (fcnt2 !== ((frames == 15) ? 4'd15 : (frames == 16) ? 4'd0 : 4'd1)) begin
            n_fail++; $display("FAIL wrap_edge frames=%0d got %0d", frames, fcnt2);
          end
        end
      end
      done = 1'b0;
      if (bus2.s_tvalid && bus2.s_tready) acc++;
      if (bus2.m_tvalid && bus2.m_tlast) begin frames++; done = 1'b1; end
    end
    n_chk++;
    if (frames != 17) begin n_fail++; $display("FAIL wrap_frames got %0d want 17", frames); end
  endtask

  initial begin
    bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.m_tready = 1'b0;
    bus2.s_tvalid = 1'b0; bus2.s_tdata = '0; bus2.m_tready = 1'b0;
    test_reset();
    test_single(16'h0712, "single");
    test_back_to_back();
    test_backpressure();
    test_single(16'hF712, "msb_ignored");
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
